// File: rtl/mux_sel_rr_reg_pkg.sv
// Shared constants for the registered N:1 selector / round-robin arbiter.
// Mode encodings are the only values shared between the selector and its users.
package mux_sel_rr_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mux_sel_rr_reg_rr_pick.sv
// Rotating priority encoder: the first asserted request found while walking
// from ptr upward and wrapping mod N wins. Purely combinational.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [SW-1:0] idx;

    // Walk exactly N positions; the wrap keeps idx inside 0..N-1 for non-pow2 N.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = ptr;
        for (int k = 0; k < N; k++) begin
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_sel_rr_reg.sv
// N-channel, W-bit registered selector with valid/ready on every input and on the
// output; fixed-select or round-robin grant, single output register at full throughput.
module mux_sel_rr_reg
    import mux_sel_rr_reg_pkg::*;
#(
    parameter int W = 5,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] s,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [W-1:0]  out_data_reg,  out_data_next;
    logic [SW-1:0] out_src_reg,   out_src_next;
    logic          out_valid_reg, out_valid_next;
    logic [SW-1:0] rr_ptr_reg,    rr_ptr_next;

    logic [W-1:0]  ch_data [N];
    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic          s_in_range;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic          load_en;
    logic          xfer;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*W +: W];
            assign in_ready[gi] = xfer && (gnt_idx == SW'(gi));
        end
        // A select value beyond the last channel only exists when N is not a power of two.
        if ((1 << SW) == N) begin : g_pow2
            assign s_in_range = 1'b1;
        end else begin : g_npow2
            assign s_in_range = (s <= LAST);
        end
    endgenerate

    rr_pick #(.N(N)) u_rr_pick (
        .req     (in_valid),
        .ptr     (rr_ptr_reg),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end else begin
            gnt_idx = s;
            gnt_any = s_in_range && in_valid[s];
        end
    end

    // Gating with rst_n keeps every in_ready low while reset is held.
    assign load_en = !out_valid_reg || out_ready;
    assign xfer    = rst_n && load_en && gnt_any;

    always_comb begin
        out_data_next  = out_data_reg;
        out_src_next   = out_src_reg;
        out_valid_next = out_valid_reg;
        rr_ptr_next    = rr_ptr_reg;
        if (xfer) begin
            out_data_next  = ch_data[gnt_idx];
            out_src_next   = gnt_idx;
            out_valid_next = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_next = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= '0;
        end else begin
            out_data_reg  <= out_data_next;
            out_src_reg   <= out_src_next;
            out_valid_reg <= out_valid_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_sel_rr_reg.sv
// Bench for mux_sel_rr_reg: directed scenarios plus randomized traffic on an N=4
// instance, and a non-power-of-two N=3 instance for the select range check.
module tb_mux_sel_rr_reg;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [19:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4;
    logic [1:0]  s4;
    logic [4:0]  out_data4;
    logic [1:0]  out_src4;
    logic        out_valid4, out_ready4;

    logic [14:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3;
    logic [1:0]  s3;
    logic [4:0]  out_data3;
    logic [1:0]  out_src3;
    logic        out_valid3, out_ready3;

    int errors = 0;
    int checks = 0;

    // Reference state of the N=4 output stage
    bit m_valid;
    int m_data, m_src, m_ptr;

    always #5 clk = ~clk;

    mux_sel_rr_reg #(.W(5), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .mode(mode4), .s(s4), .out_data(out_data4),
        .out_src(out_src4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

    mux_sel_rr_reg #(.W(5), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .s(s3), .out_data(out_data3),
        .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    // Channel winning the grant, or -1 when none.
    function automatic int ref_grant(int n, bit md, int sel, int vmask, int ptr);
        if (!md) return (sel < n && vmask[sel]) ? sel : -1;
        for (int k = 0; k < n; k++) begin
            if (vmask[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic int exp_ready4();
        int g;
        if (!rst_n) return 0;
        g = ref_grant(4, mode4, int'(s4), int'(in_valid4), m_ptr);
        if ((!m_valid || out_ready4) && g >= 0) return 1 << g;
        return 0;
    endfunction

    // Advance one clock and update the reference from the inputs seen at the edge.
    task automatic cycle4();
        int g;
        bit le;
        g  = ref_grant(4, mode4, int'(s4), int'(in_valid4), m_ptr);
        le = !m_valid || out_ready4;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        end else if (le && g >= 0) begin
            m_data  = int'((in_data4 >> (g * 5)) & 20'h1f);
            m_src   = g;
            m_valid = 1;
            if (mode4) m_ptr = (g + 1) % 4;
        end else if (m_valid && out_ready4) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid4 = 4'b1111; in_data4 = 20'hfffff; mode4 = 0; s4 = 0; out_ready4 = 1;
        in_valid3 = 3'b111; in_data3 = 15'h7fff; mode3 = 0; s3 = 0; out_ready3 = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (in_ready4 !== 4'b0000) begin
                errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready4);
            end
            cycle4();
        end
        checks += 3;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid4); end
        if (out_data4 !== 5'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data4); end
        if (out_src4 !== 2'd0) begin errors++; $display("FAIL reset_out_src: got %0d want 0", out_src4); end
        $display("reset: out_valid=%b out_data=%h out_src=%0d", out_valid4, out_data4, out_src4);
        rst_n = 1; in_valid4 = 0; in_valid3 = 0;
        cycle4();
    endtask

    task automatic test_fixed();
        mode4 = 0; s4 = 2; in_data4 = {5'h03, 5'h15, 5'h0a, 5'h01}; in_valid4 = 4'b1111; out_ready4 = 1;
        #1;
        checks++;
        if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b want 0100", in_ready4); end
        cycle4();
        checks += 3;
        if (out_data4 !== 5'h15) begin errors++; $display("FAIL fixed_out_data: got %h want 15", out_data4); end
        if (out_src4 !== 2'd2) begin errors++; $display("FAIL fixed_out_src: got %0d want 2", out_src4); end
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL fixed_out_valid: got %b want 1", out_valid4); end
        $display("fixed: s=2 out_data=%h out_src=%0d", out_data4, out_src4);
    endtask

    task automatic test_round_robin();
        int want_src [6] = '{0, 1, 3, 0, 1, 3};
        mode4 = 1; in_valid4 = 4'b1011; out_ready4 = 1;
        for (int c = 0; c < 6; c++) begin
            in_data4 = 20'($urandom);
            #1;
            checks++;
            if (in_ready4 !== 4'(1 << want_src[c])) begin
                errors++; $display("FAIL rr_in_ready[%0d]: got %b want %b", c, in_ready4, 4'(1 << want_src[c]));
            end
            cycle4();
            checks += 2;
            if (out_src4 !== 2'(want_src[c])) begin
                errors++; $display("FAIL rr_out_src[%0d]: got %0d want %0d", c, out_src4, want_src[c]);
            end
            if (out_data4 !== 5'(m_data)) begin
                errors++; $display("FAIL rr_out_data[%0d]: got %h want %h", c, out_data4, 5'(m_data));
            end
            $display("rr: step=%0d out_src=%0d out_data=%h", c, out_src4, out_data4);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] held_data;
        logic [1:0] held_src;
        mode4 = 0; s4 = 1; in_valid4 = 4'b0010; out_ready4 = 0;
        held_data = out_data4; held_src = out_src4;
        for (int c = 0; c < 3; c++) begin
            in_data4[9:5] = 5'(c + 7);
            #1;
            checks++;
            if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, in_ready4); end
            cycle4();
            checks += 3;
            if (out_data4 !== held_data) begin errors++; $display("FAIL bp_out_data[%0d]: got %h want %h", c, out_data4, held_data); end
            if (out_src4 !== held_src) begin errors++; $display("FAIL bp_out_src[%0d]: got %0d want %0d", c, out_src4, held_src); end
            if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid4); end
            $display("backpressure: cycle=%0d out_data=%h frozen", c, out_data4);
        end
        out_ready4 = 1; in_data4[9:5] = 5'h1c;
        #1;
        checks++;
        if (in_ready4 !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", in_ready4); end
        cycle4();
        checks += 3;
        if (out_data4 !== 5'h1c) begin errors++; $display("FAIL bp_release_data: got %h want 1c", out_data4); end
        if (out_src4 !== 2'd1) begin errors++; $display("FAIL bp_release_src: got %0d want 1", out_src4); end
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b want 1", out_valid4); end
        $display("backpressure: released out_data=%h", out_data4);
    endtask

    task automatic test_nonpow2();
        mode3 = 0; s3 = 3; in_valid3 = 3'b111; in_data3 = {5'h11, 5'h0d, 5'h05}; out_ready3 = 1;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin errors++; $display("FAIL n3_s3_ready: got %b want 000", in_ready3); end
        cycle4();
        checks++;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL n3_s3_valid: got %b want 0", out_valid3); end
        s3 = 1;
        #1;
        checks++;
        if (in_ready3 !== 3'b010) begin errors++; $display("FAIL n3_s1_ready: got %b want 010", in_ready3); end
        cycle4();
        checks += 3;
        if (out_valid3 !== 1'b1) begin errors++; $display("FAIL n3_s1_valid: got %b want 1", out_valid3); end
        if (out_src3 !== 2'd1) begin errors++; $display("FAIL n3_s1_src: got %0d want 1", out_src3); end
        if (out_data3 !== 5'h0d) begin errors++; $display("FAIL n3_s1_data: got %h want 0d", out_data3); end
        $display("nonpow2: s=3 no grant, s=1 out_data=%h", out_data3);
        in_valid3 = 0;
    endtask

    task automatic test_mid_reset();
        mode4 = 1; in_valid4 = 4'b0010; out_ready4 = 1;
        cycle4();
        checks++;
        if (m_ptr != 2 || out_valid4 !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: out_valid=%b want 1 (ref ptr %0d want 2)", out_valid4, m_ptr);
        end
        in_valid4 = 4'b1111; rst_n = 0;
        cycle4();
        checks++;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid4); end
        rst_n = 1;
        #1;
        checks++;
        if (in_ready4 !== 4'b0001) begin errors++; $display("FAIL midrst_ready: got %b want 0001", in_ready4); end
        cycle4();
        checks++;
        if (out_src4 !== 2'd0) begin errors++; $display("FAIL midrst_src: got %0d want 0", out_src4); end
        $display("mid_reset: first grant after reset from ch%0d", out_src4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst_n      = ($urandom_range(0, 39) != 0);
            in_data4   = 20'($urandom);
            in_valid4  = 4'($urandom);
            mode4      = 1'($urandom);
            s4         = 2'($urandom);
            out_ready4 = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready4 !== 4'(exp_ready4())) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready4, 4'(exp_ready4()));
            end
            cycle4();
            checks += 3;
            if (out_valid4 !== m_valid) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", c, out_valid4, m_valid); end
            if (out_data4 !== 5'(m_data)) begin errors++; $display("FAIL rand_out_data[%0d]: got %h want %h", c, out_data4, 5'(m_data)); end
            if (out_src4 !== 2'(m_src)) begin errors++; $display("FAIL rand_out_src[%0d]: got %0d want %0d", c, out_src4, m_src); end
            $display("random: cycle=%0d valid=%b src=%0d data=%h", c, out_valid4, out_src4, out_data4);
        end
        rst_n = 1;
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        @(posedge clk); #1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_nonpow2();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
